// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage.
// Owns the PC and fetches one word at a time over a req/ack memory port.
// Each word is held stable until the core reports exec_done, and then the
// next PC is committed from NPCOp/rs_data. A misaligned next PC halts fetch
// until reset.
//   clk, rstn            : clock, synchronous active-low reset
//   imem_req/addr        : fetch request and address (addr is a copy of pc)
//   imem_ack/rdata       : memory response
//   instr, instr_valid   : held instruction and its valid flag
//   pc, pc_plus4         : held instruction address and its link value
//   exec_done, NPCOp     : completion strobe and next-PC select
//   rs_data              : register target for jr/jalr
//   misalign             : sticky halt flag
//   retire_cnt           : completed-instruction count
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic [3:0]  NPCOp,
  input  logic [31:0] rs_data,
  output logic        misalign,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        misalign_q;
  logic [31:0] retire_q;

  logic [31:0] npc_d;
  logic [31:0] pc_plus4_d;
  logic [31:0] br_off;

  always_comb begin
    pc_plus4_d = pc_q + 32'd4;
    br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    npc_d      = pc_plus4_d;
    case (NPCOp)
      4'd0:    npc_d = pc_plus4_d;
      4'd1:    npc_d = pc_plus4_d + br_off;
      4'd2:    npc_d = {pc_plus4_d[31:28], instr_q[25:0], 2'b00};
      4'd3,
      4'd4:    npc_d = rs_data;
      default: npc_d = pc_plus4_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_FETCH;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      instr_q    <= '0;
      misalign_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (exec_done) begin
            pc_q     <= npc_d;
            retire_q <= retire_q + 32'd1;
            if (npc_d[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state_q    <= S_HALT;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Request/valid are state decodes gated by rstn so they drop in the reset cycle.
  assign imem_req    = rstn && (state_q == S_FETCH);
  assign instr_valid = rstn && (state_q == S_VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_d;
  assign instr       = instr_q;
  assign misalign    = misalign_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic [3:0]  NPCOp;
  logic [31:0] rs_data;
  logic        misalign;
  logic [31:0] retire_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_retire = '0;

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .exec_done  (exec_done),
    .NPCOp      (NPCOp),
    .rs_data    (rs_data),
    .misalign   (misalign),
    .retire_cnt (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word at exp_addr with a given number of wait cycles before ack.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int unsigned waits);
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("addr", imem_addr, exp_addr);
    for (int unsigned i = 0; i < waits; i++) begin
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_addr);
      chk("wait_ivalid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    chk("ivalid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, word);
    chk("pc", pc, exp_addr);
    chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    chk("req_off", {31'd0, imem_req}, 32'd0);
  endtask

  // Hold exec_done low for 'hold' cycles, then complete with op/rs.
  task automatic execute(input logic [3:0] op, input logic [31:0] rs, input int unsigned hold,
                         input logic [31:0] exp_npc);
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    held_instr = instr;
    held_pc    = pc;
    for (int unsigned i = 0; i < hold; i++) begin
      NPCOp   = 4'd2;
      rs_data = 32'h0000_0001;
      tick();
      chk("frz_instr", instr, held_instr);
      chk("frz_pc", pc, held_pc);
      chk("frz_ivalid", {31'd0, instr_valid}, 32'd1);
    end
    NPCOp     = op;
    rs_data   = rs;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    NPCOp     = 4'd0;
    rs_data   = '0;
    exp_retire = exp_retire + 32'd1;
    chk("npc", pc, exp_npc);
    chk("retire", retire_cnt, exp_retire);
    chk("ivalid_fall", {31'd0, instr_valid}, 32'd0);
    chk("misalign", {31'd0, misalign}, {31'd0, (exp_npc[1:0] != 2'b00)});
    chk("req_next", {31'd0, imem_req}, {31'd0, (exp_npc[1:0] == 2'b00)});
  endtask

  initial begin
    rstn       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exec_done  = 1'b0;
    NPCOp      = '0;
    rs_data    = '0;
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    rstn = 1'b1;
    #1;

    // Sequential PLUS4 with zero-wait memory
    fetch(32'h3000, 32'h2108_0001, 0);
    execute(4'd0, '0, 0, 32'h3004);
    fetch(32'h3004, 32'h2108_0002, 0);
    execute(4'd0, '0, 0, 32'h3008);
    fetch(32'h3008, 32'h2108_0003, 0);
    execute(4'd0, '0, 0, 32'h300C);
    chk("retire3", retire_cnt, 32'd3);

    // Unused NPCOp encoding behaves as PLUS4
    fetch(32'h300C, 32'h0000_0000, 0);
    execute(4'd9, 32'h0000_5550, 0, 32'h3010);

    // Backward branch: 0x3014 + (-2 << 2) = 0x300C
    fetch(32'h3010, 32'h1000_FFFE, 0);
    execute(4'd1, '0, 0, 32'h300C);

    // Forward branch: 0x3010 + (4 << 2) = 0x3020
    fetch(32'h300C, 32'h1000_0004, 0);
    execute(4'd1, '0, 0, 32'h3020);

    // Jump: {0x0, 0x0000C10, 00} = 0x3040
    fetch(32'h3020, 32'h0800_0C10, 0);
    execute(4'd2, 32'hFFFF_0000, 0, 32'h3040);

    // jr with 3 ack wait cycles and 4 exec_done hold cycles
    fetch(32'h3040, 32'h03E0_0008, 3);
    execute(4'd3, 32'h0000_3100, 4, 32'h3100);

    // jalr to a misaligned target halts fetch
    fetch(32'h3100, 32'h0060_F809, 0);
    execute(4'd4, 32'h0000_3102, 0, 32'h3102);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    exec_done  = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_ivalid", {31'd0, instr_valid}, 32'd0);
    end
    chk("halt_pc", pc, 32'h0000_3102);
    chk("halt_instr", instr, 32'h0060_F809);
    chk("halt_misalign", {31'd0, misalign}, 32'd1);
    chk("halt_retire", retire_cnt, exp_retire);
    imem_ack  = 1'b0;
    exec_done = 1'b0;

    // Reset leaves HALT and refetches from 0x3000
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    exp_retire = '0;
    #1;
    chk("rst2_misalign", {31'd0, misalign}, 32'd0);
    chk("rst2_retire", retire_cnt, 32'd0);
    fetch(32'h3000, 32'h2108_0001, 0);
    execute(4'd0, '0, 0, 32'h3004);

    // Reset mid-FETCH with a late ack during reset
    tick();
    chk("pend_req", {31'd0, imem_req}, 32'd1);
    rstn       = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_mid_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rst_mid_instr", instr, 32'd0);
    chk("rst_mid_ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mid_pc", pc, 32'h0000_3000);
    imem_ack = 1'b0;
    rstn     = 1'b1;
    exp_retire = '0;
    #1;

    // PLUS4 wrap from 0xFFFF_FFFC to 0
    fetch(32'h3000, 32'h03E0_0008, 0);
    execute(4'd3, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 0);
    chk("wrap_p4", pc_plus4, 32'h0000_0000);
    execute(4'd0, '0, 0, 32'h0000_0000);
    fetch(32'h0000_0000, 32'h2108_0005, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the main decoder `ctrl`. It owns the PC and fetches instruction words over a req/ack instruction-memory port. It holds each word stable for decode and execute. When execution completes, it takes the next-PC select (`NPCOp`, same encoding the decoder produces) and `rs` data, and computes and commits the next PC.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC after reset; bits [1:0] forced to 00.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  synchronous active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction; bits [31:26] drive decoder `Op`, bits [5:0] drive decoder `Funct`.
- `instr_valid`  out  1  `instr` is valid for decode/execute.
- `pc`  out  32  address of the held instruction.
- `pc_plus4`  out  32  `pc + 4`, combinational; link value for jal/jalr.
- `exec_done`  in  1  core finished the held instruction; `NPCOp` and `rs_data` are valid this cycle.
- `NPCOp`  in  4  next-PC select from the decoder.
- `rs_data`  in  32  GPR[rs], the target for jr/jalr.
- `misalign`  out  1  sticky flag: a computed next PC had bits [1:0] ≠ 00; fetch is halted.
- `retire_cnt`  out  32  count of completed instructions.

## Operation
- States:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - VALID: `instr_valid`=1.
  - HALT: all requests off.
- Reset (`rstn`=0 at an edge), applied in any state:
  - state ← FETCH, `pc` ← {`RESET_PC`[31:2],2'b00}, `instr` ← 0, `misalign` ← 0, `retire_cnt` ← 0.
  - While `rstn`=0: `imem_req`=0 and `instr_valid`=0, overriding the state decode.
- FETCH:
  - Hold `imem_req`=1 and a constant `imem_addr` until `imem_ack`.
  - On an edge with `imem_ack`=1: `instr` ← `imem_rdata`, go to VALID.
- VALID:
  - `instr` and `pc` are frozen.
  - `exec_done`=0: stay in VALID.
  - `exec_done`=1: `pc` ← npc and `retire_cnt` ← `retire_cnt`+1 (wraps mod 2^32). Go to HALT if npc[1:0] ≠ 00 (also set `misalign`), else go to FETCH.
- Next-PC computation (all arithmetic mod 2^32; carry out discarded):
  - 0 PLUS4: `pc`+4.
  - 1 BRANCH: `pc`+4 + (sign-extend(`instr`[15:0]) << 2).
  - 2 JUMP: {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - 3 JR and 4 JALR: `rs_data`.
  - 5–15 (unused): treated as PLUS4.
- HALT:
  - `imem_req`=0, `instr_valid`=0.
  - `pc` holds the offending value for debug.
  - Only reset exits HALT.
- `imem_ack` outside FETCH, or while `rstn`=0, is ignored.
- `exec_done` outside VALID is ignored.
- A `pc` wrap from 32'hFFFF_FFFC to 32'h0000_0000 via PLUS4 is legal and is not an error.

## Timing
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction (FETCH, VALID).
- N wait cycles on ack: 2+N cycles per instruction.
- `instr_valid` rises on the edge that captures `imem_ack`. It falls on the edge that samples `exec_done`=1.
- `imem_req` for the new `pc` asserts in the cycle immediately after the `exec_done` edge.
- No instruction is ever fetched speculatively.
- `misalign` asserts on the same edge that commits the bad `pc`, and stays asserted until reset.
- `retire_cnt` increments on the `exec_done` edge, including the one that causes HALT.
- Reset during FETCH with a request outstanding: `imem_req` drops in the reset cycle. The first fetch after `rstn` rises is to `RESET_PC`.
- All outputs are registered except `pc_plus4`, `imem_addr` (wire copy of `pc`) and `imem_req`/`instr_valid` (state decode gated by `rstn`).

## Test plan
- Reset release with `RESET_PC`=32'h0000_3000 and ack in the same cycle as req:
  - `imem_addr`=0x3000 on the first cycle.
  - `instr_valid` high on the second cycle.
  - Three instructions with NPCOp=0 → addresses 0x3000, 0x3004, 0x3008; `retire_cnt`=3.
- Branch at `pc`=0x3010 with `instr`[15:0]=16'hFFFE and NPCOp=1 → next fetch 0x300C.
- Jump and register targets:
  - j with `pc`=0x3020 and `instr`[25:0]=26'h0000C10 → next fetch 0x0000_3040.
  - jr with NPCOp=3 and `rs_data`=0x3100 → next fetch 0x3100.
- Wait states:
  - `imem_ack` delayed 3 cycles → `imem_req`/`imem_addr` stay stable and the instruction takes 5 cycles.
  - `exec_done` held low 4 cycles → `instr`/`pc` stay frozen.
- Misalignment: NPCOp=4 with `rs_data`=0x3102:
  - `misalign`=1 and `pc`=0x3102, then `imem_req` stays 0 indefinitely.
  - Asserting `rstn`=0 clears `misalign` and refetches from 0x3000.
- Reset and wrap edge cases:
  - `rstn`=0 mid-FETCH with a late `imem_ack` arriving during reset → the ack is ignored and `instr`=0.
  - PLUS4 from 0xFFFF_FFFC → `pc`=0x0000_0000 with `misalign`=0.
